// File: rtl/out_fifo_reg.sv
// Stage-2 -> stage-3 output buffer: DEPTH-entry first-word-fall-through FIFO with
// valid/ready drain, almost-full back-pressure, flush, sticky overflow and stall forwarding.
module out_fifo_reg #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int AF_LVL = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       stalled,
    input  logic                       flush,
    input  logic                       dataoutvx2,
    input  logic [DATA_W-1:0]          dataoutx2,
    input  logic                       out_ready,
    output logic                       stalledx3,
    output logic                       dataoutvx3,
    output logic [DATA_W-1:0]          dataoutx3,
    output logic                       out_afull,
    output logic                       out_ovf,
    output logic [$clog2(DEPTH):0]     out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic wr_req;
    logic rd;
    logic full;
    logic wr;
    logic drop;

    // A full buffer still takes a write when the head leaves in the same cycle.
    always_comb begin
        wr_req = dataoutvx2 & ~stalled;
        full   = (count == CNT_W'(DEPTH));
        rd     = dataoutvx3 & out_ready;
        wr     = wr_req & (~full | rd);
        drop   = wr_req & full & ~rd;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            stalledx3 <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            stalledx3 <= stalled;
            if (drop) begin
                out_ovf <= 1'b1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (rd) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(wr) - CNT_W'(rd);
            end
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by count alone,
    // so clearing it would only cost reset fan-out.
    always_ff @(posedge clock) begin
        if (!reset && !flush && wr) begin
            mem[wr_ptr] <= dataoutx2;
        end
    end

    always_comb begin
        dataoutvx3 = (count != '0);
        dataoutx3  = dataoutvx3 ? mem[rd_ptr] : '0;
        out_afull  = (count >= CNT_W'(AF_LVL));
        out_count  = count;
    end

endmodule

// File: tb/tb_out_fifo_reg.sv
// Self-checking bench for out_fifo_reg: a queue model tracks accepted writes and is
// compared against the DUT head, valid, count, flags and stall forwarding every cycle.
module tb_out_fifo_reg;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int AF_LVL = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              stalled;
    logic              flush;
    logic              dataoutvx2;
    logic [DATA_W-1:0] dataoutx2;
    logic              out_ready;
    logic              stalledx3;
    logic              dataoutvx3;
    logic [DATA_W-1:0] dataoutx3;
    logic              out_afull;
    logic              out_ovf;
    logic [$clog2(DEPTH):0] out_count;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic              ovf_exp = 1'b0;
    logic              stall_prev = 1'b0;
    logic              mon_en = 1'b0;

    out_fifo_reg #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LVL(AF_LVL)) dut (
        .clock      (clock),
        .reset      (reset),
        .stalled    (stalled),
        .flush      (flush),
        .dataoutvx2 (dataoutvx2),
        .dataoutx2  (dataoutx2),
        .out_ready  (out_ready),
        .stalledx3  (stalledx3),
        .dataoutvx3 (dataoutvx3),
        .dataoutx3  (dataoutx3),
        .out_afull  (out_afull),
        .out_ovf    (out_ovf),
        .out_count  (out_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply inputs for one clock edge, return at posedge+1.
    task automatic drive(input logic v2, input logic [DATA_W-1:0] d, input logic stl,
                         input logic rdy, input logic fl);
        dataoutvx2 = v2;
        dataoutx2  = d;
        stalled    = stl;
        out_ready  = rdy;
        flush      = fl;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Mid-cycle scoreboard: check current DUT state, then advance the model
    // with the inputs that the coming edge will see.
    always @(negedge clock) begin
        if (mon_en) begin
            check("count", 32'(out_count), 32'(exp_q.size()));
            check("valid", 32'(dataoutvx3), 32'(exp_q.size() != 0));
            check("afull", 32'(out_afull), 32'(exp_q.size() >= AF_LVL));
            check("ovf", 32'(out_ovf), 32'(ovf_exp));
            check("stalledx3", 32'(stalledx3), 32'(stall_prev));
            if (exp_q.size() != 0) check("head", 32'(dataoutx3), 32'(exp_q[0]));
            else                   check("empty_data", 32'(dataoutx3), 32'h0);

            if (reset) begin
                exp_q.delete();
                ovf_exp    = 1'b0;
                stall_prev = 1'b0;
            end else begin
                automatic logic wr_req = dataoutvx2 & ~stalled;
                automatic logic rd_m   = (exp_q.size() != 0) & out_ready;
                automatic logic full_m = (exp_q.size() == DEPTH);
                stall_prev = stalled;
                if (wr_req && full_m && !rd_m) ovf_exp = 1'b1;
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (rd_m) void'(exp_q.pop_front());
                    if (wr_req && (!full_m || rd_m)) exp_q.push_back(dataoutx2);
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        stalled    = 1'b0;
        flush      = 1'b0;
        dataoutvx2 = 1'b0;
        dataoutx2  = '0;
        out_ready  = 1'b0;
        @(posedge clock);
        #1;
        mon_en = 1'b1;
        idle(1);
        reset = 1'b0;

        // Reset state after idle cycles.
        idle(3);
        check("rst_valid", 32'(dataoutvx3), 32'h0);
        check("rst_data", 32'(dataoutx3), 32'h0);
        check("rst_count", 32'(out_count), 32'h0);
        check("rst_stalledx3", 32'(stalledx3), 32'h0);
        check("rst_ovf", 32'(out_ovf), 32'h0);

        // Three writes held, then drained in order.
        drive(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        check("fwft_valid", 32'(dataoutvx3), 32'h1);
        check("fwft_data", 32'(dataoutx3), 32'h1111);
        drive(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
        check("t2_count", 32'(out_count), 32'd3);
        check("t2_afull", 32'(out_afull), 32'h1);
        check("t2_head", 32'(dataoutx3), 32'h1111);
        idle(2);
        check("t2_hold", 32'(dataoutx3), 32'h1111);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t2_empty", 32'(out_count), 32'h0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("empty_read", 32'(out_count), 32'h0);

        // Fill, drop on full, then write-with-read on full.
        for (int i = 1; i <= 4; i++) drive(1'b1, 16'(16'h4400 + i), 1'b0, 1'b0, 1'b0);
        check("t3_full", 32'(out_count), 32'd4);
        check("t3_ovf_pre", 32'(out_ovf), 32'h0);
        drive(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
        check("t3_ovf", 32'(out_ovf), 32'h1);
        check("t3_count", 32'(out_count), 32'd4);
        drive(1'b1, 16'h6666, 1'b0, 1'b1, 1'b0);
        check("t3_count_rw", 32'(out_count), 32'd4);
        check("t3_head", 32'(dataoutx3), 32'h4402);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t3_empty", 32'(out_count), 32'h0);

        // Stalled write is not taken; stall forwarded one cycle later.
        dataoutvx2 = 1'b1;
        dataoutx2  = 16'hAAAA;
        stalled    = 1'b1;
        check("t4_stx3_pre", 32'(stalledx3), 32'h0);
        drive(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
        check("t4_count", 32'(out_count), 32'h0);
        check("t4_stx3", 32'(stalledx3), 32'h1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("t4_stx3_fall", 32'(stalledx3), 32'h0);

        // Flush with simultaneous write.
        for (int i = 1; i <= 3; i++) drive(1'b1, 16'(16'h7700 + i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h7777, 1'b0, 1'b0, 1'b1);
        check("t5_count", 32'(out_count), 32'h0);
        check("t5_valid", 32'(dataoutvx3), 32'h0);
        check("t5_ovf", 32'(out_ovf), 32'h1);
        idle(2);
        check("t5_still_empty", 32'(out_count), 32'h0);

        // Pointer wrap with toggling ready.
        for (int i = 0; i < 10; i++) drive(1'b1, 16'(16'hB000 + i), 1'b0, (i % 4) != 0, 1'b0);
        for (int i = 0; i < 8 && out_count != 0; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t6_drained", 32'(out_count), 32'h0);

        // Reset mid-operation with a write pending.
        drive(1'b1, 16'hC001, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'hC002, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'hC003, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b1, 16'hC004, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        check("t7_count", 32'(out_count), 32'h0);
        check("t7_ovf", 32'(out_ovf), 32'h0);
        check("t7_stx3", 32'(stalledx3), 32'h0);
        idle(2);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
